// File: rtl/sign_extend.sv
// Sign-extends an ID-stage immediate; result/result_shl2/is_neg are zero-latency.
// result_q/valid_q are registered one cycle later; no backpressure, accepts every cycle.
module sign_extend #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] result,
    output logic [OUT_W-1:0] result_shl2,
    output logic             is_neg,
    output logic [OUT_W-1:0] result_q,
    output logic             valid_q
);

    logic [OUT_W-1:0] result_d;
    logic             valid_d;

    assign result      = {{(OUT_W-IN_W){in[IN_W-1]}}, in};
    // Top two bits fall off; the branch adder only needs the word-aligned low bits.
    assign result_shl2 = {result[OUT_W-3:0], 2'b00};
    assign is_neg      = in[IN_W-1];

    always_comb begin
        result_d = result;
        valid_d  = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

endmodule

// File: tb/tb_sign_extend.sv
// Bench for sign_extend: fixed vector table, reset sequences, random registered path, full sweep.
module tb_sign_extend;

    logic        clk;
    logic        rst;
    logic [15:0] in;
    logic [31:0] result;
    logic [31:0] result_shl2;
    logic        is_neg;
    logic [31:0] result_q;
    logic        valid_q;

    int n_cmp;
    int n_bad;

    sign_extend #(.IN_W(16), .OUT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in),
        .result      (result),
        .result_shl2 (result_shl2),
        .is_neg      (is_neg),
        .result_q    (result_q),
        .valid_q     (valid_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] in;
        logic [31:0] res;
        logic [31:0] shl2;
        logic        neg;
    } vec_t;

    vec_t vecs[8];

    // Reference: interpret the 16-bit pattern as a two's-complement number.
    function automatic longint ref_val(input logic [15:0] v);
        longint s;
        s = longint'(v);
        if (s >= 32768) s = s - 65536;
        return s;
    endfunction

    function automatic logic [31:0] ref_res(input logic [15:0] v);
        longint s;
        s = ref_val(v);
        if (s < 0) s = s + 64'd4294967296;
        return s[31:0];
    endfunction

    function automatic logic [31:0] ref_shl2(input logic [15:0] v);
        longint s;
        s = ref_val(v) * 4;
        s = s % 64'sd4294967296;
        if (s < 0) s = s + 64'sd4294967296;
        return s[31:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_comb(input string tag, input logic [15:0] v);
        check({tag, " result"}, result, ref_res(v));
        check({tag, " shl2"}, result_shl2, ref_shl2(v));
        check({tag, " is_neg"}, {31'd0, is_neg}, {31'd0, ref_val(v) < 0});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        in    = 16'h0000;

        vecs[0] = '{16'h0001, 32'h00000001, 32'h00000004, 1'b0};
        vecs[1] = '{16'h8000, 32'hFFFF8000, 32'hFFFE0000, 1'b1};
        vecs[2] = '{16'h7FFF, 32'h00007FFF, 32'h0001FFFC, 1'b0};
        vecs[3] = '{16'hFFFF, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b1};
        vecs[4] = '{16'h0000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[5] = '{16'h4000, 32'h00004000, 32'h00010000, 1'b0};
        vecs[6] = '{16'hC001, 32'hFFFFC001, 32'hFFFF0004, 1'b1};
        vecs[7] = '{16'h1234, 32'h00001234, 32'h000048D0, 1'b0};

        // Reset state, held across clock edges
        #1;
        check("reset result_q", result_q, 32'h0);
        check("reset valid_q", {31'd0, valid_q}, 32'h0);
        @(posedge clk); #1;
        check("reset hold result_q", result_q, 32'h0);
        check("reset hold valid_q", {31'd0, valid_q}, 32'h0);

        // Combinational table, still in reset
        for (int i = 0; i < 8; i++) begin
            in = vecs[i].in;
            #1;
            check($sformatf("vec%0d result", i), result, vecs[i].res);
            check($sformatf("vec%0d shl2", i), result_shl2, vecs[i].shl2);
            check($sformatf("vec%0d is_neg", i), {31'd0, is_neg}, {31'd0, vecs[i].neg});
        end

        // Release reset between edges: outputs stay 0 until the next rising edge
        @(negedge clk);
        in  = 16'h8000;
        rst = 1'b0;
        #1;
        check("release pre-edge result_q", result_q, 32'h0);
        check("release pre-edge valid_q", {31'd0, valid_q}, 32'h0);
        @(posedge clk); #1;
        check("first edge result_q", result_q, 32'hFFFF8000);
        check("first edge valid_q", {31'd0, valid_q}, 32'h1);

        // Asynchronous assert mid-cycle; combinational path untouched
        #2;
        rst = 1'b1;
        #1;
        check("async rst result_q", result_q, 32'h0);
        check("async rst valid_q", {31'd0, valid_q}, 32'h0);
        check("async rst result", result, 32'hFFFF8000);
        @(negedge clk);
        rst = 1'b0;

        // Random stimulus: registered copy lags one edge
        for (int i = 0; i < 300; i++) begin
            logic [15:0] v;
            @(negedge clk);
            v  = 16'($urandom);
            in = v;
            #1;
            check_comb("rand", v);
            @(posedge clk); #1;
            check("rand result_q", result_q, ref_res(v));
            check("rand valid_q", {31'd0, valid_q}, 32'h1);
        end

        // Full sweep of the input range
        for (int v = 0; v < 65536; v++) begin
            in = v[15:0];
            #1;
            check_comb("sweep", v[15:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
